// File: rtl/serial_addsub.sv
// serial_addsub -- bit-serial two's-complement adder/subtractor.
//
// Operands load in parallel on an accepted start; one result bit is formed
// per clock, LSB first, by a full-add cell made of two half adders plus a
// carry flop. After WIDTH run cycles the result, carry-out and signed
// overflow are loaded into the output registers and done pulses once.
//
// Parameters:
//   WIDTH      operand/result width, 2..64 (default 16)
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   start      operation request (accepted in IDLE or DONE)
//   sub        0: a + b, 1: a - b (sampled with start)
//   a, b       signed operands (sampled with start)
//   busy       high while bits are being processed
//   done       one-cycle pulse: sum/carry_out/ovf were just updated
//   sum        result, held until the next done
//   carry_out  carry out of the MSB (for subtract, 1 = no borrow)
//   ovf        signed overflow of the last result
//   state_dbg  current FSM state (0 IDLE, 1 RUN, 2 DONE)
//
// Compile-time option:
//   SERIAL_ADDSUB_SAT_EN  when defined, an overflowing result saturates to
//                         the most positive / most negative value, chosen
//                         by the sign of a. carry_out and ovf are unchanged.
//
// Handshake: a request is taken on any rising edge where start = 1 and the
// block is not busy (IDLE or DONE). There is no queueing: start while busy
// is dropped. sub, a and b matter only on the accepting edge.

module half_adder (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);
    assign s = x ^ y;
    assign c = x & y;
endmodule

module serial_addsub #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             ovf,
    output logic [1:0]       state_dbg
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_n;
    logic   accept;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-2:0] res_sr;   // upper result bits collected so far
    logic             c;        // running carry
    logic [CW-1:0]    cnt;
`ifdef SERIAL_ADDSUB_SAT_EN
    logic             a_sign;   // sign of operand a, picks saturation rail
`endif

    // Full-add cell from two half adders.
    logic s1, c1, s_bit, c2, c_next;

    half_adder u_ha0 (.x(a_sr[0]), .y(b_sr[0]), .s(s1),    .c(c1));
    half_adder u_ha1 (.x(s1),      .y(c),       .s(s_bit), .c(c2));
    assign c_next = c1 | c2;

    // Result as it stands once the current bit is included; on the last
    // run cycle this is the complete WIDTH-bit sum.
    logic [WIDTH-1:0] res_full;
    assign res_full = {s_bit, res_sr};

    logic last_bit;
    assign last_bit = (state == RUN) && (cnt == LAST);

    // Next-state logic.
    always_comb begin
        state_n = state;
        accept  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_n = RUN;
                end
            end
            RUN: begin
                if (cnt == LAST) state_n = DONE;
            end
            DONE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_n = RUN;
                end else begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            a_sr      <= '0;
            b_sr      <= '0;
            res_sr    <= '0;
            c         <= 1'b0;
            cnt       <= '0;
            sum       <= '0;
            carry_out <= 1'b0;
            ovf       <= 1'b0;
`ifdef SERIAL_ADDSUB_SAT_EN
            a_sign    <= 1'b0;
`endif
        end else begin
            state <= state_n;
            if (accept) begin
                a_sr   <= a;
                // Subtract is a + ~b + 1: the +1 enters as the initial carry.
                b_sr   <= sub ? ~b : b;
                c      <= sub;
                cnt    <= '0;
`ifdef SERIAL_ADDSUB_SAT_EN
                a_sign <= a[WIDTH-1];
`endif
            end else if (state == RUN) begin
                a_sr   <= a_sr >> 1;
                b_sr   <= b_sr >> 1;
                res_sr <= (WIDTH-1)'({s_bit, res_sr} >> 1);
                c      <= c_next;
                cnt    <= cnt + CW'(1);
            end

            if (last_bit) begin
                // c is the carry into the MSB here; c_next is the carry out.
                carry_out <= c_next;
                ovf       <= c ^ c_next;
`ifdef SERIAL_ADDSUB_SAT_EN
                if (c ^ c_next)
                    sum <= a_sign ? {1'b1, {(WIDTH-1){1'b0}}}
                                  : {1'b0, {(WIDTH-1){1'b1}}};
                else
                    sum <= res_full;
`else
                sum <= res_full;
`endif
            end
        end
    end

    assign busy      = (state == RUN);
    assign done      = (state == DONE);
    assign state_dbg = state;

endmodule

// File: doc/serial_addsub.md
# serial_addsub

Bit-serial, parametrised two's-complement adder/subtractor for the CORDIC datapath. Operands load in parallel. One result bit is produced per clock, LSB first, by a single full-add cell built from the team's half-adder primitive plus a carry flop. The block trades latency for area in the x/y/z iteration updates, where the CORDIC direction bit selects add or subtract. It reports carry-out and signed overflow, and can saturate at compile time.

## Interface
Parameters:
- WIDTH, 16, operand/result width in bits; legal range 2..64

Ports (one clock; reset is synchronous and active-high):
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- start  input  1  request; sampled only when the block can accept
- sub  input  1  0 = a + b, 1 = a − b; sampled with start
- a  input  WIDTH  operand A, signed; sampled with start
- b  input  WIDTH  operand B, signed; sampled with start
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse: result outputs updated
- sum  output  WIDTH  result; held until the next done
- carry_out  output  1  carry out of the MSB (for subtract, 1 = no borrow)
- ovf  output  1  signed overflow of the last result

## Operation
- States:
  - IDLE: accepts start.
  - RUN: bit counter runs 0..WIDTH−1.
  - DONE: held for one cycle; accepts start.
- Acceptance:
  - start=1 in IDLE or DONE → load a into shift register A.
  - Load b (sub=0) or ~b (sub=1) into shift register B.
  - Carry flop ← sub. Counter ← 0. Next state RUN.
- RUN, each cycle:
  - s = A[0] ^ B[0] ^ c; c ← majority(A[0], B[0], c).
  - s shifts into the result register MSB side; A and B shift right.
  - The carry into the MSB bit is captured for the overflow calculation.
- Exit from RUN:
  - On the cycle counter = WIDTH−1, the next state is DONE.
  - On that edge, sum, carry_out and ovf load from the completed result register.
- Overflow: ovf = carry into MSB XOR carry out of MSB.
- start=1 while in RUN: ignored, not queued.
- sub, a and b are ignored except on the accepting edge.
- Reset (any state, including mid-RUN):
  - State → IDLE; sum, carry_out, ovf, busy and done → 0.
  - The aborted operation produces no done.

## Timing
- Start sampled at edge E0:
  - busy = 1 from E0 through E0 + WIDTH.
  - On edge E0 + WIDTH: busy → 0, done → 1, outputs valid.
  - done falls at E0 + WIDTH + 1 unless a new start was sampled in DONE.
- Latency: WIDTH + 1 edges from the sampling edge of start to done falling.
- Throughput: one operation per WIDTH + 1 cycles when start is held high (back-to-back).
- busy and done are mutually exclusive.
- A start accepted in DONE:
  - done still pulses for exactly that one cycle.
  - busy rises on the same edge that done falls.
- Reset values: busy = 0, done = 0, sum = 0, carry_out = 0, ovf = 0, state IDLE.

## Configuration
- Macro SERIAL_ADDSUB_SAT_EN.
- Defined:
  - On ovf = 1, sum loads 2^(WIDTH−1)−1 if a's sign bit = 0, else −2^(WIDTH−1).
  - ovf and carry_out are still reported unmodified.
  - Latency unchanged.
- Undefined:
  - sum is the wrapped modulo-2^WIDTH result.
  - No saturation logic is present.

## Test plan
With WIDTH = 8:
- Add: a = 0x05, b = 0x03, sub = 0 → done at E0 + 8; sum = 0x08, carry_out = 0, ovf = 0; busy high for exactly 8 cycles.
- Subtract: a = 0x03, b = 0x05, sub = 1 → sum = 0xFE, carry_out = 0, ovf = 0. Then a = 0x05, b = 0x03 → sum = 0x02, carry_out = 1.
- Positive overflow: a = 0x7F, b = 0x01, sub = 0 → ovf = 1; sum = 0x80 without the macro, 0x7F with SERIAL_ADDSUB_SAT_EN.
- Negative overflow: a = 0x80, b = 0x01, sub = 1 → ovf = 1; sum = 0x7F without the macro, 0x80 with it.
- Handshake:
  - start pulsed at E0 + 3 during RUN is ignored; result unchanged.
  - start held high → back-to-back results every 9 cycles, each done a single-cycle pulse.
- Reset mid-operation: rst at E0 + 4 → busy = 0 and all outputs 0 next edge; no done. A following start for 0x05 + 0x03 still yields 0x08.
